// File: rtl/mcp3201_pkg.sv
// Shared constants, FSM state type and counter types for the dual MCP3201 reader.
// MCP3201_LSB_CHECK_EN lengthens the frame to capture the ADC's LSB-first repeat.
package mcp3201_pkg;

    localparam int unsigned DATA_W_C        = 12;
    localparam int unsigned NULL_EDGE       = 3;
    localparam int unsigned FIRST_DATA_EDGE = NULL_EDGE + 1;
    localparam int unsigned LAST_MSB_EDGE   = FIRST_DATA_EDGE + DATA_W_C - 1;

`ifdef MCP3201_LSB_CHECK_EN
    localparam int unsigned FRAME_EDGES = 26;
`else
    localparam int unsigned FRAME_EDGES = 15;
`endif

    localparam int unsigned EDGE_CNT_W = $clog2(FRAME_EDGES + 1);
    localparam int unsigned HOLD_CNT_W = 4;

    typedef logic [EDGE_CNT_W-1:0] edge_cnt_t;
    typedef logic [HOLD_CNT_W-1:0] hold_cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FALL,
        CONV,
        FINISH,
        CS_HOLD
    } state_e;

    // True for rise counts that carry the MSB-first result bits.
    function automatic logic is_msb_edge(edge_cnt_t cnt);
        return (cnt >= edge_cnt_t'(FIRST_DATA_EDGE)) && (cnt <= edge_cnt_t'(LAST_MSB_EDGE));
    endfunction

endpackage

// File: rtl/mcp3201_dual_reader_if.sv
// SPI pins and sample-pair outputs of the dual MCP3201 reader.
// master: the reader; slave: the environment driving sclk/start/MISO.
interface mcp3201_dual_reader_if #(
    parameter int unsigned DATA_W = 12
) ();

    logic              sclk_i;
    logic              start_i;
    logic              miso_a_i;
    logic              miso_b_i;
    logic              cs_n_o;
    logic              sclk_o;
    logic              busy_o;
    logic [DATA_W-1:0] data_a_o;
    logic [DATA_W-1:0] data_b_o;
    logic              valid_o;
    logic              err_o;

    modport master (
        input  sclk_i,
        input  start_i,
        input  miso_a_i,
        input  miso_b_i,
        output cs_n_o,
        output sclk_o,
        output busy_o,
        output data_a_o,
        output data_b_o,
        output valid_o,
        output err_o
    );

    modport slave (
        output sclk_i,
        output start_i,
        output miso_a_i,
        output miso_b_i,
        input  cs_n_o,
        input  sclk_o,
        input  busy_o,
        input  data_a_o,
        input  data_b_o,
        input  valid_o,
        input  err_o
    );

endinterface

// File: rtl/mcp3201_shreg.sv
// Per-channel capture: MSB-first result register and, with MCP3201_LSB_CHECK_EN,
// an LSB-first repeat register compared against result bits B11..B1.
module mcp3201_shreg
    import mcp3201_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_C
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_shift_msb,
    input  logic              i_shift_lsb,
    input  logic              i_miso,
    output logic [DATA_W-1:0] o_data,
    output logic              o_mismatch
);

    logic [DATA_W-1:0] r_msb;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_msb <= '0;
        end else if (i_shift_msb) begin
            r_msb <= {r_msb[DATA_W-2:0], i_miso};
        end
    end

    assign o_data = r_msb;

`ifdef MCP3201_LSB_CHECK_EN
    logic [DATA_W-2:0] r_lsb;

    // B1 enters first and ends up at bit 0, lining up with r_msb[DATA_W-1:1].
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lsb <= '0;
        end else if (i_shift_lsb) begin
            r_lsb <= {i_miso, r_lsb[DATA_W-2:1]};
        end
    end

    assign o_mismatch = (r_lsb != r_msb[DATA_W-1:1]);
`else
    logic w_unused_lsb;
    assign w_unused_lsb = i_shift_lsb;
    assign o_mismatch   = 1'b0;
`endif

endmodule

// File: rtl/mcp3201_dual_reader.sv
// Frame controller for two MCP3201 ADCs sharing CS_n and a gated SCLK.
// Optional macro MCP3201_LSB_CHECK_EN enables the LSB-first readback check on err_o.
module mcp3201_dual_reader
    import mcp3201_pkg::*;
#(
    parameter int unsigned DATA_W          = DATA_W_C,
    parameter int unsigned CS_HIGH_PERIODS = 1
) (
    input logic                  clock,
    input logic                  reset_n,
    mcp3201_dual_reader_if.master bus
);

    localparam hold_cnt_t HOLD_TGT   = hold_cnt_t'(CS_HIGH_PERIODS);
    localparam edge_cnt_t EDGE_FRAME = edge_cnt_t'(FRAME_EDGES);
    localparam edge_cnt_t EDGE_LAST  = edge_cnt_t'(LAST_MSB_EDGE);

    state_e            r_state;
    state_e            w_state_d;
    logic              r_sclk_q;
    logic              w_rise;
    logic              w_fall;
    logic              r_cs_n;
    logic              w_cs_n_d;
    logic              r_gate;
    logic              w_gate_d;
    logic              r_sclk_o;
    edge_cnt_t         r_edge_cnt;
    edge_cnt_t         w_edge_d;
    edge_cnt_t         w_edge_inc;
    hold_cnt_t         r_hold_cnt;
    hold_cnt_t         w_hold_d;
    hold_cnt_t         w_hold_inc;
    logic              w_shift_msb;
    logic              w_shift_lsb;
    logic              w_load;
    logic              r_valid;
    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic [DATA_W-1:0] w_sh_a;
    logic [DATA_W-1:0] w_sh_b;
    logic              w_mis_a;
    logic              w_mis_b;

    assign w_rise     = bus.sclk_i & ~r_sclk_q;
    assign w_fall     = ~bus.sclk_i & r_sclk_q;
    assign w_edge_inc = r_edge_cnt + edge_cnt_t'(1);
    assign w_hold_inc = r_hold_cnt + hold_cnt_t'(1);

    always_comb begin
        w_state_d   = r_state;
        w_cs_n_d    = r_cs_n;
        w_gate_d    = r_gate;
        w_edge_d    = r_edge_cnt;
        w_hold_d    = r_hold_cnt;
        w_shift_msb = 1'b0;
        w_shift_lsb = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start_i) begin
                    w_state_d = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                // CS_n drops and the gate opens while sclk is low, so the first
                // ADC edge seen is a full-width rise.
                if (w_fall) begin
                    w_cs_n_d  = 1'b0;
                    w_gate_d  = 1'b1;
                    w_edge_d  = '0;
                    w_state_d = CONV;
                end
            end
            CONV: begin
                if (w_rise) begin
                    w_edge_d    = w_edge_inc;
                    w_shift_msb = is_msb_edge(w_edge_inc);
`ifdef MCP3201_LSB_CHECK_EN
                    w_shift_lsb = (w_edge_inc > EDGE_LAST);
`endif
                    if (w_edge_inc == EDGE_FRAME) begin
                        w_state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                if (w_fall) begin
                    w_gate_d  = 1'b0;
                    w_cs_n_d  = 1'b1;
                    w_hold_d  = '0;
                    w_state_d = CS_HOLD;
                end
            end
            CS_HOLD: begin
                if (w_fall) begin
                    w_hold_d = w_hold_inc;
                    if (w_hold_inc == HOLD_TGT) begin
                        w_load    = 1'b1;
                        w_state_d = IDLE;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sclk_q   <= 1'b0;
            r_cs_n     <= 1'b1;
            r_gate     <= 1'b0;
            r_sclk_o   <= 1'b0;
            r_edge_cnt <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_sclk_q   <= bus.sclk_i;
            r_cs_n     <= w_cs_n_d;
            r_gate     <= w_gate_d;
            r_sclk_o   <= bus.sclk_i & r_gate;
            r_edge_cnt <= w_edge_d;
            r_hold_cnt <= w_hold_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_data_a <= '0;
            r_data_b <= '0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_data_a <= w_sh_a;
                r_data_b <= w_sh_b;
            end
        end
    end

    mcp3201_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_shift_msb (w_shift_msb),
        .i_shift_lsb (w_shift_lsb),
        .i_miso      (bus.miso_a_i),
        .o_data      (w_sh_a),
        .o_mismatch  (w_mis_a)
    );

    mcp3201_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_shift_msb (w_shift_msb),
        .i_shift_lsb (w_shift_lsb),
        .i_miso      (bus.miso_b_i),
        .o_data      (w_sh_b),
        .o_mismatch  (w_mis_b)
    );

`ifdef MCP3201_LSB_CHECK_EN
    logic r_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_load) begin
            r_err <= w_mis_a | w_mis_b;
        end
    end

    assign bus.err_o = r_err;
`else
    logic w_unused_mis;
    assign w_unused_mis = w_mis_a | w_mis_b;
    assign bus.err_o    = 1'b0;
`endif

    assign bus.cs_n_o   = r_cs_n;
    assign bus.sclk_o   = r_sclk_o;
    assign bus.busy_o   = (r_state != IDLE);
    assign bus.data_a_o = r_data_a;
    assign bus.data_b_o = r_data_b;
    assign bus.valid_o  = r_valid;

endmodule
